// File: rtl/fp_int_to_f32_seq_pkg.sv
// Shared types and constants for the sequential integer to binary32 converter.
//   word_t   : 32-bit integer operand
//   fp32_t   : IEEE-754 binary32 value {sign, exp[7:0], mant[22:0]}
//   fflags_t : exception flags {NV, DZ, OF, UF, NX}
//   FRM_*    : rounding-mode encodings (5..7 behave as RNE)
//   state_e  : converter FSM states
package fp_int_to_f32_seq_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] fp32_t;
  typedef logic [4:0]  fflags_t;

  localparam logic [2:0] FRM_RNE = 3'd0;
  localparam logic [2:0] FRM_RTZ = 3'd1;
  localparam logic [2:0] FRM_RDN = 3'd2;
  localparam logic [2:0] FRM_RUP = 3'd3;
  localparam logic [2:0] FRM_RMM = 3'd4;

  // Biased exponent of 2^31: magnitude bit 31 is the hidden bit before normalisation.
  localparam logic [7:0] EXP_INIT = 8'd158;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StNorm  = 2'd1,
    StRound = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_rounder_f32.sv
// Combinational rounding step for a normalised binary32 significand.
//   sign_i             : result sign (direction for RDN/RUP)
//   rm_i               : rounding mode, FRM_* encoding
//   mant_i             : 23-bit truncated mantissa
//   guard_i/round_i/sticky_i : bits below the mantissa
//   exp_i              : biased exponent before rounding
//   mant_o / exp_o     : rounded mantissa and exponent
//   inexact_o          : any discarded bit was set
module fp_rounder_f32
  import fp_int_to_f32_seq_pkg::*;
(
  input  logic        sign_i,
  input  logic [2:0]  rm_i,
  input  logic [22:0] mant_i,
  input  logic        guard_i,
  input  logic        round_i,
  input  logic        sticky_i,
  input  logic [7:0]  exp_i,
  output logic [22:0] mant_o,
  output logic [7:0]  exp_o,
  output logic        inexact_o
);

  logic        inc;
  logic [23:0] mant_sum;

  assign inexact_o = guard_i | round_i | sticky_i;

  always_comb begin
    inc = 1'b0;
    case (rm_i)
      FRM_RTZ: inc = 1'b0;
      FRM_RDN: inc = sign_i & inexact_o;
      FRM_RUP: inc = ~sign_i & inexact_o;
      FRM_RMM: inc = guard_i;
      default: inc = guard_i & (round_i | sticky_i | mant_i[0]);
    endcase
  end

  assign mant_sum = {1'b0, mant_i} + {23'd0, inc};

  // Carry-out means the significand became 2.0: mantissa wraps to 0 and the
  // exponent bumps. A 32-bit source never reaches the binary32 overflow range.
  assign mant_o = mant_sum[22:0];
  assign exp_o  = exp_i + {7'd0, mant_sum[23]};

endmodule

// File: rtl/fp_int_to_f32_seq.sv
// Multi-cycle i32/u32 to binary32 converter.
//   clk, rst     : clock and synchronous active-high reset
//   start        : request, accepted when start && ready
//   intSigned    : 1 = operand is i32, 0 = u32 (sampled on accept)
//   roundingMode : FRM_* rounding mode (sampled on accept)
//   intSrc       : integer operand (sampled on accept)
//   ready        : high only while idle
//   done         : one-cycle result-valid pulse
//   fpResult     : converted value, held until the next result
//   flags        : exception flags {NV,DZ,OF,UF,NX}, held with fpResult
module fp_int_to_f32_seq
  import fp_int_to_f32_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       intSigned,
  input  logic [2:0] roundingMode,
  input  word_t      intSrc,
  output logic       ready,
  output logic       done,
  output fp32_t      fpResult,
  output fflags_t    flags
);

  state_e     state_q, state_d;
  word_t      mag_q, mag_d;
  logic [7:0] exp_q, exp_d;
  logic       sign_q, sign_d;
  logic [2:0] rm_q, rm_d;
  fp32_t      result_q, result_d;
  fflags_t    flags_q, flags_d;

  logic [22:0] rnd_mant;
  logic [7:0]  rnd_exp;
  logic        rnd_inexact;
  logic        src_sign;

  fp_rounder_f32 u_rounder (
    .sign_i    (sign_q),
    .rm_i      (rm_q),
    .mant_i    (mag_q[30:8]),
    .guard_i   (mag_q[7]),
    .round_i   (mag_q[6]),
    .sticky_i  (|mag_q[5:0]),
    .exp_i     (exp_q),
    .mant_o    (rnd_mant),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact)
  );

  assign src_sign = intSigned & intSrc[31];

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    rm_d     = rm_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d = src_sign;
          // Two's-complement negate; 0x8000_0000 maps to itself, which is the
          // correct magnitude when read as unsigned.
          mag_d  = src_sign ? (~intSrc + 32'd1) : intSrc;
          exp_d  = EXP_INIT;
          rm_d   = roundingMode;
          if (intSrc == '0) begin
            result_d = '0;
            flags_d  = '0;
            state_d  = StDone;
          end else begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (mag_q[31]) begin
          state_d = StRound;
        end else if (mag_q[31:24] == 8'd0) begin
          mag_d = mag_q << 8;
          exp_d = exp_q - 8'd8;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      StRound: begin
        result_d = {sign_q, rnd_exp, rnd_mant};
        flags_d  = {4'b0000, rnd_inexact};
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      rm_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      rm_q     <= rm_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign done     = (state_q == StDone);
  assign fpResult = result_q;
  assign flags    = flags_q;

endmodule

// File: tb/tb_fp_int_to_f32_seq.sv
// Self-checking bench for fp_int_to_f32_seq: directed corner cases, random
// operands against an arithmetic reference model, busy-start and mid-op reset.
module tb_fp_int_to_f32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        intSigned;
  logic [2:0]  roundingMode;
  logic [31:0] intSrc;
  logic        ready;
  logic        done;
  logic [31:0] fpResult;
  logic [4:0]  flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_int_to_f32_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .intSigned    (intSigned),
    .roundingMode (roundingMode),
    .intSrc       (intSrc),
    .ready        (ready),
    .done         (done),
    .fpResult     (fpResult),
    .flags        (flags)
  );

  // Reference: exact value |src| = 2^p * 1.f, rounded by comparing the discarded
  // remainder against half an ulp. Latency from the shift schedule needed to
  // bring the leading one to bit 31 (coarse steps of 8, then single steps).
  task automatic model(input logic sgn, input logic [2:0] rm, input logic [31:0] src,
                       output logic [31:0] res, output logic [4:0] flg, output int lat);
    logic        neg;
    longint      mag, kept, rem, half;
    int          p, sh, e, s;
    logic        inexact, inc;
    neg = sgn && src[31];
    mag = neg ? (longint'(64'h1_0000_0000) - longint'(src)) : longint'(src);
    if (src == 32'd0) begin
      res = 32'd0; flg = 5'd0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (mag >= (longint'(1) << i)) p = i;
    e = 127 + p;
    inc = 1'b0;
    if (p <= 23) begin
      kept = mag << (23 - p);
      inexact = 1'b0;
    end else begin
      sh   = p - 23;
      kept = mag >> sh;
      rem  = mag & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      inexact = (rem != 0);
      case (rm)
        3'd1: inc = 1'b0;
        3'd2: inc = neg && inexact;
        3'd3: inc = !neg && inexact;
        3'd4: inc = (rem >= half);
        default: inc = (rem > half) || (rem == half && kept[0]);
      endcase
    end
    kept = kept + (inc ? 1 : 0);
    if (kept == (longint'(1) << 24)) begin
      kept = longint'(1) << 23;
      e = e + 1;
    end
    res = {neg, 8'(e), kept[22:0]};
    flg = {4'b0000, inexact};
    s   = 31 - p;
    lat = 3 + s / 8 + s % 8;
  endtask

  // Waits for ready, issues one request, and reports result and done latency
  // (1 = done in the cycle right after the accepting edge). lat = -1 on timeout.
  task automatic run_conv(input logic sgn, input logic [2:0] rm, input logic [31:0] src,
                          output logic [31:0] res, output logic [4:0] flg, output int lat);
    int guard;
    guard = 0;
    while (!ready && guard < 64) begin
      @(posedge clk); #1; guard++;
    end
    intSigned = sgn; roundingMode = rm; intSrc = src; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    intSrc = $urandom;
    lat = 1;
    while (!done && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    if (!done) lat = -1;
    res = fpResult; flg = flags;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; intSigned = 1'b0; roundingMode = 3'd0; intSrc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (fpResult !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", fpResult); end
    checks++; if (flags !== 5'd0) begin errors++; $display("FAIL reset_flags got=%h exp=0", flags); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        sgn;
    logic [2:0]  rm;
    logic [31:0] src;
    logic [31:0] res;
    logic        nx;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[9];
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
    v[0] = '{1'b0, 3'd0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 13};
    v[1] = '{1'b1, 3'd0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 3};
    v[2] = '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 13};
    v[3] = '{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1, 3};
    v[4] = '{1'b0, 3'd1, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 1'b1, 3};
    v[5] = '{1'b1, 3'd0, 32'h0100_0001, 32'h4B80_0000, 1'b1, 10};
    v[6] = '{1'b1, 3'd3, 32'h0100_0001, 32'h4B80_0001, 1'b1, 10};
    v[7] = '{1'b1, 3'd2, 32'hFEFF_FFFF, 32'hCB80_0001, 1'b1, 10};
    v[8] = '{1'b1, 3'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1};
    foreach (v[i]) begin
      run_conv(v[i].sgn, v[i].rm, v[i].src, res, flg, lat);
      checks++;
      if (res !== v[i].res)
        begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, v[i].res); end
      checks++;
      if (flg !== {4'b0000, v[i].nx})
        begin errors++; $display("FAIL dir%0d_flags got=%h exp=%h", i, flg, {4'b0000, v[i].nx}); end
      checks++;
      if (lat != v[i].lat)
        begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); end
      // The cycle after done: back in idle, result still held.
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || fpResult !== v[i].res)
        begin errors++; $display("FAIL dir%0d_hold got=%b%b/%h exp=10/%h",
                                 i, ready, done, fpResult, v[i].res); end
    end
  endtask

  task automatic test_random();
    logic [31:0] src, res, eres;
    logic [4:0]  flg, eflg;
    logic [2:0]  rm;
    logic        sgn;
    int          lat, elat;
    for (int n = 0; n < 300; n++) begin
      src = $urandom;
      case ($urandom_range(0, 3))
        0: src = src >> $urandom_range(0, 31);
        1: src = ~(src >> $urandom_range(0, 31));
        2: if ($urandom_range(0, 9) == 0) src = 32'd0;
        default: ;
      endcase
      sgn = 1'($urandom_range(0, 1));
      rm  = 3'($urandom_range(0, 7));
      model(sgn, rm, src, eres, eflg, elat);
      run_conv(sgn, rm, src, res, flg, lat);
      checks++;
      if (res !== eres || flg !== eflg || lat != elat)
        begin errors++; $display("FAIL rand%0d s=%b rm=%0d src=%h got=%h/%h/%0d exp=%h/%h/%0d",
                                 n, sgn, rm, src, res, flg, lat, eres, eflg, elat); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, extra;
    @(posedge clk); #1;
    intSigned = 1'b0; roundingMode = 3'd0; intSrc = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", ready); end
    // Intruding request while busy.
    intSigned = 1'b1; roundingMode = 3'd1; intSrc = 32'h8000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 64) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 13) begin errors++; $display("FAIL busy_latency got=%0d exp=13", lat); end
    checks++;
    if (fpResult !== 32'h3F80_0000 || flags !== 5'd0)
      begin errors++; $display("FAIL busy_result got=%h/%h exp=3f800000/00", fpResult, flags); end
    extra = 0;
    repeat (20) begin @(posedge clk); #1; if (done) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_queued got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat, seen;
    intSigned = 1'b0; roundingMode = 3'd0; intSrc = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || fpResult !== 32'd0 || flags !== 5'd0)
      begin errors++; $display("FAIL midrst_outputs got=%b%b/%h/%h exp=10/0/0",
                               ready, done, fpResult, flags); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_done got=%0d exp=0", seen); end
    run_conv(1'b1, 3'd0, 32'hFFFF_FFFF, res, flg, lat);
    checks++;
    if (res !== 32'hBF80_0000 || flg !== 5'd0 || lat != 13)
      begin errors++; $display("FAIL midrst_next got=%h/%h/%0d exp=bf800000/00/13", res, flg, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, eres;
    logic [4:0]  flg, eflg;
    int          lat, elat;
    logic [31:0] srcs[4];
    srcs[0] = 32'h7FFF_FFFF; srcs[1] = 32'h0000_0000; srcs[2] = 32'h00FF_FFFF; srcs[3] = 32'h8000_0001;
    foreach (srcs[i]) begin
      model(1'b1, 3'd4, srcs[i], eres, eflg, elat);
      run_conv(1'b1, 3'd4, srcs[i], res, flg, lat);
      checks++;
      if (res !== eres || flg !== eflg || lat != elat)
        begin errors++; $display("FAIL b2b%0d got=%h/%h/%0d exp=%h/%h/%0d",
                                 i, res, flg, lat, eres, eflg, elat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
